dummy_lzc_arbiter: RTL and testbench

Round-robin controller that shares one `lzc` (common_cells leading/trailing-zero counter) among `NumReq` requesters inside the dummy VIP. Each requester submits an operand over a valid/ready handshake. The arbiter grants one requester, registers the operand and sequences it through the single `lzc` instance. It returns count, empty flag and requester ID on one response channel. One operation is in flight at a time.

---
 rtl/dummy_lzc_pkg.sv | 21 ++
 rtl/dummy_lzc_arbiter_lzc.sv | 36 +++
 rtl/dummy_lzc_arbiter.sv | 115 +++++++++++
 tb/tb_dummy_lzc_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dummy_lzc_pkg.sv
// Shared types and width helpers for the dummy LZC arbiter slice.
package dummy_lzc_pkg;

  // Controller states: accept a request, run the counter, present the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Same rule as cf_math_pkg::idx_width: bits needed to index n items, never below 1.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

  // Width of a zero count over a w-bit operand (all-zero reported separately).
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 32'd1) ? $clog2(w) : 32'd1;
  endfunction

endpackage

// File: rtl/dummy_lzc_arbiter_lzc.sv
// Leading/trailing zero counter with the common_cells lzc interface.
// MODE=0 counts trailing zeros, MODE=1 counts leading zeros; empty_o flags an
// all-zero input, in which case cnt_o carries no meaning.
module lzc
  import dummy_lzc_pkg::*;
#(
  parameter int unsigned WIDTH = 2,
  parameter bit          MODE  = 1'b0,
  localparam int unsigned CNT_WIDTH = cnt_width(WIDTH)
) (
  input  logic [WIDTH-1:0]     in_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 empty_o
);

  // Scan so the bit closest to the counted end is visited last and wins;
  // in both modes the count for scan step k works out to WIDTH-1-k.
  always_comb begin
    cnt_o   = '0;
    empty_o = 1'b1;
    for (int k = 0; k < int'(WIDTH); k++) begin
      if (MODE) begin
        if (in_i[k]) begin
          cnt_o   = CNT_WIDTH'(int'(WIDTH) - 1 - k);
          empty_o = 1'b0;
        end
      end else begin
        if (in_i[int'(WIDTH) - 1 - k]) begin
          cnt_o   = CNT_WIDTH'(int'(WIDTH) - 1 - k);
          empty_o = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/dummy_lzc_arbiter.sv
// Round-robin front end sharing a single lzc among NumReq requesters.
// One operation is in flight at a time: IDLE grants, CALC captures the
// counter result, RESP holds the response until the consumer takes it.
module dummy_lzc_arbiter
  import dummy_lzc_pkg::*;
#(
  parameter int unsigned NumReq = 4,
  parameter int unsigned Width  = 32,
  parameter bit          Mode   = 1'b0,
  localparam int unsigned IdW  = id_width(NumReq),
  localparam int unsigned CntW = cnt_width(Width)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumReq-1:0]             req_valid_i,
  output logic [NumReq-1:0]             req_ready_o,
  input  logic [NumReq-1:0][Width-1:0]  req_data_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [IdW-1:0]                rsp_id_o,
  output logic [CntW-1:0]               rsp_cnt_o,
  output logic                          rsp_empty_o,
  output logic                          busy_o
);

  state_e            r_state;
  state_e            w_state_next;
  logic [IdW-1:0]    r_rr;
  logic [IdW-1:0]    r_id;
  logic [Width-1:0]  r_op;
  logic [CntW-1:0]   r_cnt;
  logic              r_empty;

  logic              w_gnt_found;
  logic [IdW-1:0]    w_gnt_idx;
  logic              w_grant;
  logic [CntW-1:0]   w_lzc_cnt;
  logic              w_lzc_empty;

  // Priority search starting just after the last winner, wrapping around,
  // so a continuously valid requester waits at most NumReq operations.
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    for (int k = 1; k <= int'(NumReq); k++) begin
      if (!w_gnt_found && req_valid_i[(int'(r_rr) + k) % int'(NumReq)]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = IdW'((int'(r_rr) + k) % int'(NumReq));
      end
    end
  end

  // A grant only happens in IDLE; held off while reset is asserted so no
  // requester sees a handshake that the registers would not record.
  assign w_grant     = rst_ni && (r_state == IDLE) && w_gnt_found;
  assign req_ready_o = w_grant ? (NumReq'(1) << w_gnt_idx) : '0;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; RESP waits on the consumer without issuing grants.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (w_gnt_found) w_state_next = CALC;
      CALC:    w_state_next = RESP;
      RESP:    if (rsp_ready_i) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Operand/ID capture on grant and result capture in CALC; the count is
  // zeroed for an all-zero operand so the response never shows a stale value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr    <= IdW'(NumReq - 1);
      r_id    <= '0;
      r_op    <= '0;
      r_cnt   <= '0;
      r_empty <= 1'b0;
    end else begin
      if ((r_state == IDLE) && w_gnt_found) begin
        r_op <= req_data_i[w_gnt_idx];
        r_id <= w_gnt_idx;
        r_rr <= w_gnt_idx;
      end
      if (r_state == CALC) begin
        r_cnt   <= w_lzc_empty ? '0 : w_lzc_cnt;
        r_empty <= w_lzc_empty;
      end
    end
  end

  lzc #(
    .WIDTH (Width),
    .MODE  (Mode)
  ) i_lzc (
    .in_i    (r_op),
    .cnt_o   (w_lzc_cnt),
    .empty_o (w_lzc_empty)
  );

  assign busy_o      = (r_state != IDLE);
  assign rsp_valid_o = (r_state == RESP);
  assign rsp_id_o    = r_id;
  assign rsp_cnt_o   = r_cnt;
  assign rsp_empty_o = r_empty;

endmodule

// File: tb/tb_dummy_lzc_arbiter.sv
// Directed bench: a trailing-zero instance for arbitration/handshake
// scenarios and a leading-zero instance for the counting mode.
module tb_dummy_lzc_arbiter;

  logic             clk;
  logic             rst_n;

  logic [3:0]       req_valid;
  logic [3:0]       req_ready;
  logic [3:0][31:0] req_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [1:0]       rsp_id;
  logic [4:0]       rsp_cnt;
  logic             rsp_empty;
  logic             busy;

  logic [3:0]       lz_valid;
  logic [3:0]       lz_ready;
  logic [3:0][31:0] lz_data;
  logic             lz_rsp_valid;
  logic             lz_rsp_ready;
  logic [1:0]       lz_rsp_id;
  logic [4:0]       lz_rsp_cnt;
  logic             lz_rsp_empty;
  logic             lz_busy;

  int checks = 0;
  int errors = 0;

  dummy_lzc_arbiter #(.NumReq(4), .Width(32), .Mode(1'b0)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_data_i  (req_data),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_id_o    (rsp_id),
    .rsp_cnt_o   (rsp_cnt),
    .rsp_empty_o (rsp_empty),
    .busy_o      (busy)
  );

  dummy_lzc_arbiter #(.NumReq(4), .Width(32), .Mode(1'b1)) dut_lz (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (lz_valid),
    .req_ready_o (lz_ready),
    .req_data_i  (lz_data),
    .rsp_valid_o (lz_rsp_valid),
    .rsp_ready_i (lz_rsp_ready),
    .rsp_id_o    (lz_rsp_id),
    .rsp_cnt_o   (lz_rsp_cnt),
    .rsp_empty_o (lz_rsp_empty),
    .busy_o      (lz_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus-only reset pulse; leaves the bench at a falling edge in IDLE.
  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0) begin errors++; $display("[TB] FAIL reset_ready got=%b exp=%b", req_ready, 4'b0); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    checks++; if ({rsp_id, rsp_cnt, rsp_empty} !== 8'h00) begin errors++; $display("[TB] FAIL reset_rsp_fields got=%h exp=00", {rsp_id, rsp_cnt, rsp_empty}); end
    checks++; if ({lz_ready, lz_rsp_valid, lz_busy} !== 6'b0) begin errors++; $display("[TB] FAIL reset_lz_ctrl got=%b exp=000000", {lz_ready, lz_rsp_valid, lz_busy}); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_trailing_single();
    rsp_ready   = 1'b1;
    req_data[0] = 32'h0000_0100;
    req_valid   = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL single_ready got=%b exp=0001", req_ready); end
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    checks++; if ({busy, rsp_valid} !== 2'b10) begin errors++; $display("[TB] FAIL single_calc busy/valid got=%b exp=10", {busy, rsp_valid}); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_rsp_valid got=%b exp=1", rsp_valid); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("[TB] FAIL single_id got=%0d exp=0", rsp_id); end
    checks++; if (rsp_cnt !== 5'd8) begin errors++; $display("[TB] FAIL single_cnt got=%0d exp=8", rsp_cnt); end
    checks++; if (rsp_empty !== 1'b0) begin errors++; $display("[TB] FAIL single_empty got=%b exp=0", rsp_empty); end
    @(negedge clk);
    checks++; if ({busy, rsp_valid} !== 2'b00) begin errors++; $display("[TB] FAIL single_done busy/valid got=%b exp=00", {busy, rsp_valid}); end
  endtask

  task automatic test_all_zero();
    req_data[2] = 32'h0000_0000;
    req_valid   = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("[TB] FAIL zero_ready got=%b exp=0100", req_ready); end
    @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL zero_rsp_valid got=%b exp=1", rsp_valid); end
    checks++; if (rsp_empty !== 1'b1) begin errors++; $display("[TB] FAIL zero_empty got=%b exp=1", rsp_empty); end
    checks++; if (rsp_cnt !== 5'd0) begin errors++; $display("[TB] FAIL zero_cnt got=%0d exp=0", rsp_cnt); end
    checks++; if (rsp_id !== 2'd2) begin errors++; $display("[TB] FAIL zero_id got=%0d exp=2", rsp_id); end
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    logic [3:0] expReady;
    do_reset();
    for (int i = 0; i < 4; i++) req_data[i] = 32'h1 << (i + 4);
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int op = 0; op < 6; op++) begin
      expReady = 4'b0001 << (op % 4);
      #1;
      checks++; if (req_ready !== expReady) begin errors++; $display("[TB] FAIL rr_grant op=%0d got=%b exp=%b", op, req_ready, expReady); end
      @(negedge clk);
      #1;
      checks++; if (req_ready !== 4'b0) begin errors++; $display("[TB] FAIL rr_calc_ready op=%0d got=%b exp=0000", op, req_ready); end
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(op % 4)) begin errors++; $display("[TB] FAIL rr_rsp op=%0d valid=%b id=%0d exp valid=1 id=%0d", op, rsp_valid, rsp_id, op % 4); end
      checks++; if (rsp_cnt !== 5'((op % 4) + 4)) begin errors++; $display("[TB] FAIL rr_cnt op=%0d got=%0d exp=%0d", op, rsp_cnt, (op % 4) + 4); end
      @(negedge clk);
    end
    req_valid = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    do_reset();
    rsp_ready   = 1'b0;
    req_data[1] = 32'h0000_0010;
    req_data[2] = 32'h0000_0004;
    req_valid   = 4'b0110;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("[TB] FAIL bp_first_grant got=%b exp=0010", req_ready); end
    @(negedge clk);
    req_valid = 4'b0100;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if ({rsp_valid, rsp_id, rsp_cnt, rsp_empty} !== {1'b1, 2'd1, 5'd4, 1'b0}) begin errors++; $display("[TB] FAIL bp_hold c=%0d got v=%b id=%0d cnt=%0d e=%b exp v=1 id=1 cnt=4 e=0", c, rsp_valid, rsp_id, rsp_cnt, rsp_empty); end
      checks++; if (req_ready !== 4'b0) begin errors++; $display("[TB] FAIL bp_ready c=%0d got=%b exp=0000", c, req_ready); end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_handshake_valid got=%b exp=1", rsp_valid); end
    @(negedge clk);
    #1;
    checks++; if ({rsp_valid, req_ready} !== 5'b0_0100) begin errors++; $display("[TB] FAIL bp_next_grant got v=%b ready=%b exp v=0 ready=0100", rsp_valid, req_ready); end
    @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk);
    checks++; if ({rsp_valid, rsp_id, rsp_cnt} !== {1'b1, 2'd2, 5'd2}) begin errors++; $display("[TB] FAIL bp_second_rsp got v=%b id=%0d cnt=%0d exp v=1 id=2 cnt=2", rsp_valid, rsp_id, rsp_cnt); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    rsp_ready   = 1'b1;
    req_data[3] = 32'h0000_0008;
    req_valid   = 4'b1000;
    @(negedge clk);
    req_valid = 4'b0000;
    rst_n     = 1'b0;
    #1;
    checks++; if ({busy, rsp_valid, req_ready} !== 6'b0) begin errors++; $display("[TB] FAIL midrst_ctrl got busy=%b v=%b ready=%b exp all 0", busy, rsp_valid, req_ready); end
    checks++; if ({rsp_id, rsp_cnt, rsp_empty} !== 8'h00) begin errors++; $display("[TB] FAIL midrst_fields got=%h exp=00", {rsp_id, rsp_cnt, rsp_empty}); end
    req_data[0] = 32'h0000_0004;
    req_data[1] = 32'h0000_0002;
    req_valid   = 4'b0011;
    #1;
    checks++; if (req_ready !== 4'b0) begin errors++; $display("[TB] FAIL midrst_ready_in_reset got=%b exp=0000", req_ready); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_no_rsp got=%b exp=0", rsp_valid); end
    rst_n = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL midrst_first_grant got=%b exp=0001", req_ready); end
    @(negedge clk);
    req_valid = 4'b0010;
    @(negedge clk);
    checks++; if ({rsp_valid, rsp_id, rsp_cnt} !== {1'b1, 2'd0, 5'd2}) begin errors++; $display("[TB] FAIL midrst_rsp0 got v=%b id=%0d cnt=%0d exp v=1 id=0 cnt=2", rsp_valid, rsp_id, rsp_cnt); end
    @(negedge clk);
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("[TB] FAIL midrst_second_grant got=%b exp=0010", req_ready); end
    @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk);
    checks++; if ({rsp_valid, rsp_id, rsp_cnt} !== {1'b1, 2'd1, 5'd1}) begin errors++; $display("[TB] FAIL midrst_rsp1 got v=%b id=%0d cnt=%0d exp v=1 id=1 cnt=1", rsp_valid, rsp_id, rsp_cnt); end
    @(negedge clk);
  endtask

  task automatic test_leading_zero();
    lz_rsp_ready = 1'b1;
    lz_data[3]   = 32'h0000_0001;
    lz_valid     = 4'b1000;
    #1;
    checks++; if (lz_ready !== 4'b1000) begin errors++; $display("[TB] FAIL lz_grant1 got=%b exp=1000", lz_ready); end
    @(negedge clk);
    lz_valid = 4'b0000;
    @(negedge clk);
    checks++; if ({lz_rsp_valid, lz_rsp_id, lz_rsp_cnt, lz_rsp_empty} !== {1'b1, 2'd3, 5'd31, 1'b0}) begin errors++; $display("[TB] FAIL lz_low_bit got v=%b id=%0d cnt=%0d e=%b exp v=1 id=3 cnt=31 e=0", lz_rsp_valid, lz_rsp_id, lz_rsp_cnt, lz_rsp_empty); end
    @(negedge clk);
    lz_data[3] = 32'h8000_0000;
    lz_valid   = 4'b1000;
    #1;
    checks++; if (lz_ready !== 4'b1000) begin errors++; $display("[TB] FAIL lz_grant2 got=%b exp=1000", lz_ready); end
    @(negedge clk);
    lz_valid = 4'b0000;
    @(negedge clk);
    checks++; if ({lz_rsp_valid, lz_rsp_id, lz_rsp_cnt, lz_rsp_empty} !== {1'b1, 2'd3, 5'd0, 1'b0}) begin errors++; $display("[TB] FAIL lz_high_bit got v=%b id=%0d cnt=%0d e=%b exp v=1 id=3 cnt=0 e=0", lz_rsp_valid, lz_rsp_id, lz_rsp_cnt, lz_rsp_empty); end
    @(negedge clk);
  endtask

  initial begin
    rst_n        = 1'b0;
    req_valid    = '0;
    req_data     = '0;
    rsp_ready    = 1'b1;
    lz_valid     = '0;
    lz_data      = '0;
    lz_rsp_ready = 1'b1;
    test_reset();
    test_trailing_single();
    test_all_zero();
    test_round_robin();
    test_backpressure();
    test_reset_mid_op();
    test_leading_zero();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
